// File: rtl/vram_reader.sv
// vram_reader: pipelined single-byte read client for port B of a text-VRAM BSRAM.
// Define VRAM_READER_VERIFY_EN to compile in the boot-pattern self-check engine.
module vram_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic              MEMORY_CLK,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] v_adb,
    output logic              v_ceb,
    output logic              v_oce,
    output logic              v_resetb,
    input  logic [DATA_W-1:0] v_dout,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              pass
);
    localparam int PIPE_D = RD_LATENCY + 1;

    logic              running;
    logic              accept;
    logic              issue_valid;
    logic              issue_scan;
    logic [ADDR_W-1:0] issue_addr;
    logic [PIPE_D-1:0] pipe_valid;
    logic [PIPE_D-1:0] pipe_scan;
    logic [ADDR_W-1:0] pipe_addr [PIPE_D];
    logic              exit_valid;
    logic              exit_scan;
    logic [ADDR_W-1:0] exit_addr;

    assign accept     = req_valid & req_ready;
    assign exit_valid = pipe_valid[PIPE_D-1];
    assign exit_scan  = pipe_scan[PIPE_D-1];
    assign exit_addr  = pipe_addr[PIPE_D-1];

    assign v_ceb    = running;
    assign v_oce    = running;
    assign v_resetb = 1'b0;

    // Tags ride alongside the BSRAM latency so each exits as its byte appears on v_dout.
    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            running    <= 1'b0;
            v_adb      <= '0;
            pipe_valid <= '0;
            pipe_scan  <= '0;
            for (int i = 0; i < PIPE_D; i++) pipe_addr[i] <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
        end else begin
            running    <= 1'b1;
            if (issue_valid) v_adb <= issue_addr;
            pipe_valid <= {pipe_valid[PIPE_D-2:0], issue_valid};
            pipe_scan  <= {pipe_scan[PIPE_D-2:0], issue_valid & issue_scan};
            pipe_addr[0] <= issue_addr;
            for (int i = 1; i < PIPE_D; i++) pipe_addr[i] <= pipe_addr[i-1];
            rsp_valid  <= exit_valid & ~exit_scan;
            if (exit_valid & ~exit_scan) rsp_data <= v_dout;
        end
    end

`ifdef VRAM_READER_VERIFY_EN
    // state | meaning
    // IDLE  | serving user reads, waiting for scan_start
    // ISSUE | one scan read per cycle, addresses 0..max
    // DRAIN | waiting for the last scan tags to be compared
    // DONE  | scan_done pulse, pass latched, back to IDLE
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] exp_byte;
    logic              scan_miss;

    always_comb begin
        exp_byte      = '0;
        exp_byte[6:0] = exit_addr[6:0];
    end

    assign scan_miss   = exit_valid & exit_scan & (v_dout != exp_byte);
    assign req_ready   = running & ((state == IDLE) | (state == DONE));
    assign issue_scan  = (state == ISSUE);
    assign issue_valid = accept | issue_scan;
    assign issue_addr  = issue_scan ? scan_addr : req_addr;

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            scan_addr      <= '0;
            scan_busy      <= 1'b0;
            scan_done      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (scan_miss) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_addr <= exit_addr;
            end
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        scan_addr      <= '0;
                        scan_busy      <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    scan_addr <= scan_addr + 1'b1;
                    if (scan_addr == LAST_ADDR) state <= DRAIN;
                end
                DRAIN: begin
                    if ((pipe_valid & pipe_scan) == '0) begin
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                        pass      <= (err_count == '0);
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_scan;

    assign unused_scan    = ^{scan_start, exit_addr};
    assign req_ready      = running;
    assign issue_scan     = 1'b0;
    assign issue_valid    = accept;
    assign issue_addr     = req_addr;
    assign scan_busy      = 1'b0;
    assign scan_done      = 1'b0;
    assign err_count      = '0;
    assign first_err_addr = '0;
    assign pass           = 1'b0;
`endif

endmodule

// File: tb/tb_vram_reader.sv
// tb_vram_reader: directed bench for vram_reader with a behavioural BSRAM and a response scoreboard.
// Scan checks are compiled when VRAM_READER_VERIFY_EN is defined; otherwise the scan-disabled behaviour is checked.
module tb_vram_reader;
    localparam int AW = 10;
    localparam int DW = 8;

    logic          MEMORY_CLK = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] v_adb;
    logic          v_ceb;
    logic          v_oce;
    logic          v_resetb;
    logic [DW-1:0] v_dout;
    logic          scan_start;
    logic          scan_busy;
    logic          scan_done;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          pass;

    vram_reader dut (
        .MEMORY_CLK     (MEMORY_CLK),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .v_adb          (v_adb),
        .v_ceb          (v_ceb),
        .v_oce          (v_oce),
        .v_resetb       (v_resetb),
        .v_dout         (v_dout),
        .scan_start     (scan_start),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .pass           (pass)
    );

    initial forever #5 MEMORY_CLK = ~MEMORY_CLK;

    // Behavioural BSRAM port B: address register then output register.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rd_q;
    logic [DW-1:0] dout_q;
    always @(posedge MEMORY_CLK) begin
        if (v_ceb) rd_q <= mem[v_adb];
        if (v_oce) dout_q <= rd_q;
    end
    assign v_dout = dout_q;

    int cyc = 0;
    always @(posedge MEMORY_CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge MEMORY_CLK) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            check("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic send(input logic [AW-1:0] a);
        exp_t e;
        @(negedge MEMORY_CLK);
        check("req_ready_at_send", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        e.data = mem[a];
        e.due  = cyc + 4;
        sb.push_back(e);
    endtask

    task automatic idle_req();
        @(negedge MEMORY_CLK);
        req_valid = 1'b0;
    endtask

    task automatic drain_sb(input string tag);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge MEMORY_CLK);
        check(tag, sb.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_v_adb"}, 32'(v_adb), 0);
        check({tag, "_v_ceb"}, 32'(v_ceb), 0);
        check({tag, "_v_oce"}, 32'(v_oce), 0);
        check({tag, "_v_resetb"}, 32'(v_resetb), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_scan_busy"}, 32'(scan_busy), 0);
        check({tag, "_scan_done"}, 32'(scan_done), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
        check({tag, "_first_err"}, 32'(first_err_addr), 0);
        check({tag, "_pass"}, 32'(pass), 0);
    endtask

    task automatic fill_boot();
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i & 32'h7F);
    endtask

`ifdef VRAM_READER_VERIFY_EN
    task automatic run_scan(input string tag, input bit with_req, input bit poke,
                            input int exp_err, input int exp_first, input int exp_pass);
        int c0;
        bit seen;
        bit busy_ok;
        exp_t e;
        @(negedge MEMORY_CLK);
        scan_start = 1'b1;
        c0 = cyc;
        if (with_req) begin
            req_valid = 1'b1;
            req_addr  = 10'h010;
            e.data = mem[10'h010];
            e.due  = cyc + 4;
            sb.push_back(e);
        end
        @(negedge MEMORY_CLK);
        scan_start = 1'b0;
        req_valid  = 1'b0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int n = 0; n < 1200; n++) begin
            if (scan_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (req_ready !== 1'b0 || scan_busy !== 1'b1) busy_ok = 1'b0;
            scan_start = (poke && n == 300);
            @(negedge MEMORY_CLK);
        end
        scan_start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_done_cycle"}, cyc, c0 + 1029);
        check({tag, "_busy_not_ready"}, 32'(busy_ok), 1);
        check({tag, "_err_count"}, 32'(err_count), exp_err);
        check({tag, "_first_err"}, 32'(first_err_addr), exp_first);
        check({tag, "_pass"}, 32'(pass), exp_pass);
        @(negedge MEMORY_CLK);
        check({tag, "_done_pulse_end"}, 32'(scan_done), 0);
        check({tag, "_ready_after"}, 32'(req_ready), 1);
        repeat (4) @(negedge MEMORY_CLK);
        check({tag, "_pass_held"}, 32'(pass), exp_pass);
        check({tag, "_err_held"}, 32'(err_count), exp_err);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        scan_start = 1'b0;
        fill_boot();
        repeat (3) @(negedge MEMORY_CLK);
        check_reset_vals("reset");

        rst_n = 1'b1;
        @(negedge MEMORY_CLK);
        check("post_reset_ceb", 32'(v_ceb), 1);
        check("post_reset_oce", 32'(v_oce), 1);
        check("post_reset_resetb", 32'(v_resetb), 0);
        check("post_reset_ready", 32'(req_ready), 1);

        // single read
        send(10'h005);
        idle_req();
        drain_sb("single_drained");

        // streaming across the top of the address space
        send(10'h3FD);
        send(10'h3FE);
        send(10'h3FF);
        send(10'h000);
        idle_req();
        drain_sb("stream_drained");

        // random reads with random gaps
        for (int i = 0; i < 24; i++) begin
            send(AW'($urandom_range(0, 1023)));
            if ($urandom_range(0, 2) == 0) idle_req();
        end
        idle_req();
        drain_sb("random_drained");

`ifdef VRAM_READER_VERIFY_EN
        run_scan("clean", 1'b0, 1'b0, 0, 0, 1);

        mem[10'h081] = 8'hFF;
        mem[10'h2A0] = 8'h00;
        run_scan("faulty", 1'b1, 1'b1, 2, 10'h081, 0);
        drain_sb("faulty_req_drained");
        fill_boot();

        // reset in the middle of ISSUE
        @(negedge MEMORY_CLK);
        scan_start = 1'b1;
        @(negedge MEMORY_CLK);
        scan_start = 1'b0;
        repeat (100) @(negedge MEMORY_CLK);
        check("midscan_busy", 32'(scan_busy), 1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check_reset_vals("midscan_reset");
        repeat (4) @(negedge MEMORY_CLK);
        check("midscan_no_rsp", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        @(negedge MEMORY_CLK);
        check("midscan_release_ready", 32'(req_ready), 1);
        run_scan("rescan", 1'b0, 1'b0, 0, 0, 1);
        send(10'h045);
        idle_req();
        drain_sb("after_scan_drained");
`else
        // scan_start must be inert
        begin
            bit quiet;
            quiet = 1'b1;
            @(negedge MEMORY_CLK);
            scan_start = 1'b1;
            @(negedge MEMORY_CLK);
            scan_start = 1'b0;
            for (int n = 0; n < 30; n++) begin
                if (scan_busy !== 1'b0 || scan_done !== 1'b0 || err_count !== '0 ||
                    first_err_addr !== '0 || pass !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
                @(negedge MEMORY_CLK);
            end
            check("noverify_quiet", 32'(quiet), 1);
        end

        // reset with reads in flight
        @(negedge MEMORY_CLK);
        req_valid = 1'b1;
        req_addr  = 10'h020;
        @(negedge MEMORY_CLK);
        req_addr  = 10'h021;
        @(negedge MEMORY_CLK);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check_reset_vals("midread_reset");
        repeat (4) @(negedge MEMORY_CLK);
        check("midread_no_rsp", 32'(rsp_valid), 0);
        rst_n = 1'b1;
        @(negedge MEMORY_CLK);
        check("midread_release_ready", 32'(req_ready), 1);
        send(10'h0C3);
        send(10'h0C4);
        idle_req();
        drain_sb("after_reset_drained");
`endif

        repeat (3) @(negedge MEMORY_CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
